// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
//   arb_state_t  : sequencer states
//   *_DEF        : default GAP_CYC / MAX_BYTES / TO_CYC
//   cnt_w()      : counter width able to hold 0..max_val
package uart_arb_pkg;

   typedef enum logic [2:0] {
      ARB,
      SEND,
      WAIT_LO,
      WAIT_HI,
      GAP
   } arb_state_t;

   localparam int GAP_CYC_DEF   = 2;
   localparam int MAX_BYTES_DEF = 16;
   localparam int TO_CYC_DEF    = 4;

   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmitter bundle around the UART transmit arbiter.
//   slave  : the arbiter side (takes requests and idle, drives acks,
//            grant, transmitter strobe and status)
//   master : the environment side (requesters plus transmitter)
interface uart_tx_arbiter_if;
   logic       req0, req1;
   logic [7:0] data0, data1;
   logic       last0, last1;
   logic       ack0, ack1;
   logic [1:0] grant;
   logic [7:0] send_data;
   logic       send_ena;
   logic       idle;
   logic       busy;
   logic       err;

   modport slave (
      input  req0, req1, data0, data1, last0, last1, idle,
      output ack0, ack1, grant, send_data, send_ena, busy, err
   );

   modport master (
      output req0, req1, data0, data1, last0, last1, idle,
      input  ack0, ack1, grant, send_data, send_ena, busy, err
   );
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational 2-way round-robin picker.
//   req[1:0]   : pending requests
//   last_grant : index of the requester granted most recently
//   pick[1:0]  : one-hot winner, 2'b00 when nobody requests
module uart_rr_pick (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] pick
);

   always_comb begin
      pick = 2'b00;
      // On a tie the requester that was not served last wins.
      if (req[0] && (!req[1] || last_grant))
         pick = 2'b01;
      else if (req[1])
         pick = 2'b10;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester frame arbiter / sequencer in front of the UART transmitter.
// Grants the transmitter to one requester, streams its frame byte by byte
// over the send_ena/idle handshake and inserts GAP_CYC idle cycles after
// every frame.
//   clk_9600B : UART bit clock
//   rst       : synchronous, active-high reset
//   bus       : requester + transmitter bundle (slave side)
// Parameters: GAP_CYC inter-frame gap, MAX_BYTES byte limit per grant,
// TO_CYC cycles allowed for idle to fall after send_ena.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int GAP_CYC   = GAP_CYC_DEF,
   parameter int MAX_BYTES = MAX_BYTES_DEF,
   parameter int TO_CYC    = TO_CYC_DEF
) (
   input  logic            clk_9600B,
   input  logic            rst,
   uart_tx_arbiter_if.slave bus
);

   localparam int CNT_W = cnt_w(MAX_BYTES);
   localparam int TO_W  = cnt_w(TO_CYC);
   localparam int GAP_W = cnt_w(GAP_CYC);

   localparam logic [CNT_W-1:0] BYTE_MAX = CNT_W'(MAX_BYTES);
   // Terminal counts are one below the limit because the counters start
   // at zero on the first cycle of the state.
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TO_CYC > 0) ? TO_CYC - 1 : 0);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

   arb_state_t       state;
   logic [1:0]       grant_q;
   logic             last_grant;
   logic [CNT_W-1:0] byte_cnt;
   logic [TO_W-1:0]  to_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic             last_q;
   logic [7:0]       send_data_q;
   logic             send_ena_q;
   logic [1:0]       ack_q;
   logic             busy_q;
   logic             err_q;

   logic [1:0] pick;
   logic [7:0] own_data;
   logic       own_last;

   uart_rr_pick u_pick (
      .req        ({bus.req1, bus.req0}),
      .last_grant (last_grant),
      .pick       (pick)
   );

   assign own_data = grant_q[1] ? bus.data1 : bus.data0;
   assign own_last = grant_q[1] ? bus.last1 : bus.last0;

   always_ff @(posedge clk_9600B) begin
      if (rst) begin
         state       <= ARB;
         grant_q     <= 2'b00;
         last_grant  <= 1'b1;
         byte_cnt    <= '0;
         to_cnt      <= '0;
         gap_cnt     <= '0;
         last_q      <= 1'b0;
         send_data_q <= 8'h00;
         send_ena_q  <= 1'b0;
         ack_q       <= 2'b00;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         // Strobes are single-cycle unless a state re-arms them.
         send_ena_q <= 1'b0;
         ack_q      <= 2'b00;
         err_q      <= 1'b0;

         case (state)
            ARB: begin
               if (|pick) begin
                  grant_q  <= pick;
                  byte_cnt <= '0;
                  busy_q   <= 1'b1;
                  state    <= SEND;
               end
            end

            SEND: begin
               if (bus.idle) begin
                  send_ena_q  <= 1'b1;
                  send_data_q <= own_data;
                  ack_q       <= grant_q;
                  last_q      <= own_last;
                  if (byte_cnt != BYTE_MAX)
                     byte_cnt <= byte_cnt + 1'b1;
                  to_cnt      <= '0;
                  state       <= WAIT_LO;
               end
            end

            WAIT_LO: begin
               if (!bus.idle) begin
                  state <= WAIT_HI;
               end else if (to_cnt == TO_LAST) begin
                  // Transmitter never started: drop the rest of the frame.
                  err_q   <= 1'b1;
                  gap_cnt <= '0;
                  state   <= GAP;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end

            WAIT_HI: begin
               if (bus.idle) begin
                  if (last_q || (byte_cnt == BYTE_MAX)) begin
                     gap_cnt <= '0;
                     state   <= GAP;
                  end else begin
                     state <= SEND;
                  end
               end
            end

            GAP: begin
               // Requests are deliberately not looked at here.
               if (gap_cnt == GAP_LAST) begin
                  grant_q    <= 2'b00;
                  last_grant <= grant_q[1];
                  busy_q     <= 1'b0;
                  state      <= ARB;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end

            default: state <= ARB;
         endcase
      end
   end

   assign bus.grant     = grant_q;
   assign bus.send_data = send_data_q;
   assign bus.send_ena  = send_ena_q;
   assign bus.ack0      = ack_q[0];
   assign bus.ack1      = ack_q[1];
   assign bus.busy      = busy_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter. The reference model splits each
// requester's byte stream into grants (ends at last or MAX_BYTES) and
// interleaves grants by round-robin; a monitor checks every send_ena
// against that, plus latency and gap timing.
module tb_uart_tx_arbiter;
   import uart_arb_pkg::*;

   logic clk_9600B = 1'b0;
   logic rst;
   int   cyc = 0;

   uart_tx_arbiter_if bus ();

   uart_tx_arbiter dut (
      .clk_9600B (clk_9600B),
      .rst       (rst),
      .bus       (bus)
   );

   always #5 clk_9600B = ~clk_9600B;
   always @(posedge clk_9600B) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // requester byte queues: {last, data}
   logic [8:0] rq0[$], rq1[$];
   // expected send_ena stream: {end_of_grant, owner, data}
   logic [9:0] exp_q[$];
   bit         m_last = 1'b1;

   // transmitter model: mode 0 = normal, 1 = never leaves idle
   int tx_mode = 0;
   int tx_cnt  = 0;
   bit tx_pend = 0;
   int tx_low_fix = 0;

   bit mon_en = 0;
   int n_ena  = 0;

   task automatic drive_reqs();
      logic [8:0] h;
      h = (rq0.size() > 0) ? rq0[0] : 9'h000;
      bus.req0  = (rq0.size() > 0);
      bus.data0 = h[7:0];
      bus.last0 = h[8];
      h = (rq1.size() > 0) ? rq1[0] : 9'h000;
      bus.req1  = (rq1.size() > 0);
      bus.data1 = h[7:0];
      bus.last1 = h[8];
   endtask

   task automatic model_load(input logic [8:0] s0[$], input logic [8:0] s1[$]);
      int i0 = 0, i1 = 0, n;
      bit own, eoc;
      logic [8:0] b;
      while (i0 < s0.size() || i1 < s1.size()) begin
         if (i0 < s0.size() && i1 < s1.size()) own = ~m_last;
         else own = (i0 >= s0.size());
         n = 0;
         do begin
            if (own) begin b = s1[i1]; i1++; end
            else     begin b = s0[i0]; i0++; end
            n++;
            eoc = b[8] || (n == MAX_BYTES_DEF);
            exp_q.push_back({eoc, own, b[7:0]});
         end while (!eoc);
         m_last = own;
      end
   endtask

   task automatic load(input logic [8:0] s0[$], input logic [8:0] s1[$]);
      model_load(s0, s1);
      foreach (s0[i]) rq0.push_back(s0[i]);
      foreach (s1[i]) rq1.push_back(s1[i]);
      drive_reqs();
   endtask

   task automatic gen(input int nf, output logic [8:0] s[$]);
      int len;
      s.delete();
      for (int f = 0; f < nf; f++) begin
         len = $urandom_range(1, 20);
         for (int b = 0; b < len; b++)
            s.push_back({(b == len - 1), 8'($urandom)});
      end
   endtask

   // requester and transmitter models, updated just after each edge
   initial begin
      forever begin
         @(posedge clk_9600B);
         #1;
         if (bus.ack0 && rq0.size() > 0) void'(rq0.pop_front());
         if (bus.ack1 && rq1.size() > 0) void'(rq1.pop_front());
         drive_reqs();
         if (tx_mode == 0) begin
            if (tx_cnt > 0) begin
               tx_cnt--;
               if (tx_cnt == 0) bus.idle = 1'b1;
            end
            if (tx_pend) begin
               bus.idle = 1'b0;
               tx_pend  = 0;
               tx_cnt   = (tx_low_fix > 0) ? tx_low_fix : $urandom_range(1, 10);
            end
            if (bus.send_ena) tx_pend = 1;
         end
      end
   end

   // monitor
   bit prev_ena = 0, prev_idle = 1;
   bit end_pend = 0, mid_pend = 0, nxt_vld = 0, gap_vld = 0;
   int nxt_cyc = 0, gap_cyc = 0;

   task automatic mon_clear();
      end_pend = 0; mid_pend = 0; nxt_vld = 0; gap_vld = 0;
      exp_q.delete();
   endtask

   initial begin
      logic [9:0] e;
      forever begin
         @(negedge clk_9600B);
         if (bus.send_ena) begin
            n_ena++;
            chk("ena_width", prev_ena, 1'b0);
         end
         if (mon_en) begin
            if (bus.send_ena) begin
               if (nxt_vld) begin
                  chk("lat_next", cyc, nxt_cyc);
                  nxt_vld = 0;
               end
               if (exp_q.size() == 0) begin
                  chk("ena_expected", exp_q.size(), 1);
               end else begin
                  e = exp_q.pop_front();
                  chk("ena_data", bus.send_data, e[7:0]);
                  chk("ena_grant", bus.grant, e[8] ? 2'b10 : 2'b01);
                  chk("ena_ack", {bus.ack1, bus.ack0}, e[8] ? 2'b10 : 2'b01);
                  if (e[9]) end_pend = 1; else mid_pend = 1;
               end
            end
            if (bus.err) chk("err_spurious", bus.err, 1'b0);
            if (bus.idle && !prev_idle) begin
               if (end_pend) begin
                  gap_vld = 1; gap_cyc = cyc + GAP_CYC_DEF + 1; end_pend = 0;
               end else if (mid_pend) begin
                  nxt_vld = 1; nxt_cyc = cyc + 2; mid_pend = 0;
               end
            end
            if (gap_vld && cyc == gap_cyc - 1) begin
               chk("gap_hold_grant", (bus.grant != 2'b00), 1'b1);
               chk("gap_hold_busy", bus.busy, 1'b1);
            end
            if (gap_vld && cyc == gap_cyc) begin
               chk("gap_release_grant", bus.grant, 2'b00);
               chk("gap_release_busy", bus.busy, 1'b0);
               gap_vld = 0;
            end
         end
         prev_ena  = bus.send_ena;
         prev_idle = bus.idle;
      end
   end

   task automatic wait_ena(input int bound, output int c);
      c = -1;
      for (int k = 0; k < bound; k++) begin
         @(negedge clk_9600B);
         if (bus.send_ena) begin
            c = cyc;
            break;
         end
      end
      chk("ena_seen", (c >= 0), 1'b1);
   endtask

   task automatic wait_quiet(input int bound);
      bit done = 0;
      for (int k = 0; k < bound && !done; k++) begin
         @(negedge clk_9600B);
         done = (exp_q.size() == 0) && (rq0.size() == 0) && (rq1.size() == 0)
                && !bus.busy && bus.idle && !gap_vld;
      end
      chk("quiet", done, 1'b1);
      chk("exp_drained", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      @(posedge clk_9600B); #2;
      rst = 1'b1;
      rq0.delete(); rq1.delete();
      drive_reqs();
      m_last = 1'b1;
      mon_clear();
      repeat (2) @(posedge clk_9600B);
      #2;
      rst = 1'b0;
   endtask

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog expired (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      logic [8:0] s0[$], s1[$], none[$];
      int c0, c, n0, errs;

      rst = 1'b1;
      bus.idle = 1'b1;
      drive_reqs();
      none.delete();

      // reset values
      do_reset();
      @(negedge clk_9600B);
      chk("rst_grant", bus.grant, 2'b00);
      chk("rst_send_ena", bus.send_ena, 1'b0);
      chk("rst_send_data", bus.send_data, 8'h00);
      chk("rst_ack", {bus.ack1, bus.ack0}, 2'b00);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      mon_en = 1;

      // single 3-byte frame
      tx_low_fix = 10;
      @(posedge clk_9600B); #2;
      c0 = cyc;
      s0 = '{9'h055, 9'h0A3, 9'h10F};
      load(s0, none);
      wait_ena(10, c);
      chk("lat_first", c - c0, 2);
      n0 = n_ena;
      wait_quiet(200);
      chk("single_count", n_ena - n0 + 1, 3);
      tx_low_fix = 0;

      // tie right after reset, twice
      do_reset();
      for (int r = 0; r < 2; r++) begin
         @(posedge clk_9600B); #2;
         s0 = '{{1'b1, 8'($urandom)}};
         s1 = '{{1'b1, 8'($urandom)}};
         load(s0, s1);
         wait_quiet(200);
      end

      // force-terminate: 20 bytes from requester 1, last on byte 20
      @(posedge clk_9600B); #2;
      n0 = n_ena;
      s1.delete();
      for (int b = 0; b < 20; b++) s1.push_back({(b == 19), 8'($urandom)});
      load(none, s1);
      wait_quiet(600);
      chk("force_count", n_ena - n0, 20);

      // randomized traffic
      for (int r = 0; r < 6; r++) begin
         @(posedge clk_9600B); #2;
         gen($urandom_range(0, 3), s0);
         gen($urandom_range(1, 3), s1);
         n0 = n_ena;
         load(s0, s1);
         wait_quiet(3000);
         chk("rnd_count", n_ena - n0, s0.size() + s1.size());
      end

      // handshake timeout
      mon_en = 0;
      tx_mode = 1;
      @(posedge clk_9600B); #2;
      s0 = '{9'h011, 9'h022, 9'h133};
      rq0.delete();
      foreach (s0[i]) rq0.push_back(s0[i]);
      drive_reqs();
      wait_ena(10, c);
      errs = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_9600B);
         if (bus.err) begin
            errs++;
            rq0.delete();   // requester abandons the frame
            drive_reqs();
         end
         if (k == TO_CYC_DEF) chk("to_err", bus.err, 1'b1);
         if (k == TO_CYC_DEF + GAP_CYC_DEF - 1) chk("to_grant_held", bus.grant, 2'b01);
         if (k == TO_CYC_DEF + GAP_CYC_DEF) chk("to_grant_clear", bus.grant, 2'b00);
      end
      chk("to_err_count", errs, 1);
      n0 = n_ena;
      repeat (20) @(negedge clk_9600B);
      chk("to_no_more_ena", n_ena - n0, 0);
      chk("to_busy", bus.busy, 1'b0);
      tx_mode = 0;
      m_last = 1'b0;

      // reset in WAIT_HI of byte 2
      @(posedge clk_9600B); #2;
      s0 = '{9'h0C1, 9'h0C2, 9'h0C3, 9'h1C4};
      foreach (s0[i]) rq0.push_back(s0[i]);
      drive_reqs();
      wait_ena(10, c);
      wait_ena(40, c);
      for (int k = 0; k < 10 && bus.idle; k++) @(negedge clk_9600B);
      chk("mid_in_wait_hi", bus.idle, 1'b0);
      rst = 1'b1;
      rq0.delete(); rq1.delete();
      drive_reqs();
      @(negedge clk_9600B);
      chk("mid_rst_grant", bus.grant, 2'b00);
      chk("mid_rst_ena", bus.send_ena, 1'b0);
      chk("mid_rst_data", bus.send_data, 8'h00);
      chk("mid_rst_busy", bus.busy, 1'b0);
      rst = 1'b0;
      m_last = 1'b1;
      mon_clear();
      n0 = n_ena;
      repeat (15) @(negedge clk_9600B);
      chk("mid_no_ena", n_ena - n0, 0);
      mon_en = 1;

      // transmitter busy at grant time
      @(posedge clk_9600B); #2;
      bus.idle = 1'b0;
      tx_cnt = 0; tx_pend = 0;
      s0 = '{9'h15A};
      n0 = n_ena;
      load(s0, none);
      repeat (6) @(negedge clk_9600B);
      chk("busy_tx_no_ena", n_ena - n0, 0);
      chk("busy_tx_grant", bus.grant, 2'b01);
      chk("busy_tx_busy", bus.busy, 1'b1);
      @(posedge clk_9600B); #2;
      bus.idle = 1'b1;
      c0 = cyc;
      wait_ena(5, c);
      chk("busy_tx_lat", c - c0, 1);
      wait_quiet(200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
